// File: rtl/modn_counter_pkg.sv
// ============================================================================
//  modn_counter_pkg : shared types and helpers for the modulo-N counter
//  Revision: 1.0
// ============================================================================
`default_nettype none

package modn_counter_pkg;

  localparam int W_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [W_MAX-1:0] gray_of(input logic [W_MAX-1:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/modn_tick_div.sv
// ============================================================================
//  modn_tick_div : DIV-ratio prescaler, one tick per DIV enabled cycles
//  Revision: 1.0
// ============================================================================
`default_nettype none

module modn_tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pre;

  // With DIV=1 pre never leaves 0, so every enabled cycle is a tick.
  assign tick = en & ~clr & (pre == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/modn_sync_counter.sv
// ============================================================================
//  modn_sync_counter : synchronous modulo-N up/down counter with prescaler,
//  one-shot/free-run modes and terminal-count pulse.
//  Optional Gray output enabled by MODN_CNT_GRAY_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module modn_sync_counter
  import modn_counter_pkg::*;
#(
  parameter  int MOD = 14,
  parameter  int DIV = 1,
  localparam int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
`ifdef MODN_CNT_GRAY_EN
  ,
  output logic [W-1:0] q_gray
`endif
);

  localparam logic [W-1:0] MAXV    = W'(MOD - 1);
  localparam logic [W-1:0] ZERO    = '0;
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

  state_t       state, state_nxt;
  logic         oneshot_mode, mode_nxt;
  logic [W-1:0] q_nxt;
  logic [W-1:0] stepped;
  logic         tc_nxt, done_nxt;
  logic         at_term, step_term;
  logic         tick, pre_en, pre_clr;

  // Higher-priority commands in the same cycle suppress the tick and restart the prescaler.
  assign pre_en  = en & (state == ST_RUN);
  assign pre_clr = load | stop | start;

  modn_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  always_comb begin
    at_term   = 1'b0;
    stepped   = q;
    step_term = 1'b0;
    if (up) begin
      at_term   = (q == MAXV);
      stepped   = at_term ? ZERO : q + ONE;
      step_term = (stepped == MAXV);
    end else begin
      at_term   = (q == ZERO);
      stepped   = at_term ? MAXV : q - ONE;
      step_term = (stepped == ZERO);
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = oneshot_mode;
    q_nxt     = q;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      q_nxt = ({1'b0, load_val} >= MOD_EXT) ? MAXV : load_val;
      if (state == ST_DONE) begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b0;
      end
    end else if (stop) begin
      if (state == ST_RUN) state_nxt = ST_IDLE;
    end else if (start) begin
      if (state != ST_RUN) begin
        state_nxt = ST_RUN;
        mode_nxt  = oneshot;
        done_nxt  = 1'b0;
        if (state == ST_DONE) q_nxt = up ? ZERO : MAXV;
      end
    end else if (tick) begin
      if (oneshot_mode) begin
        // One-shot never wraps: a tick already at terminal just finishes.
        if (!at_term) q_nxt = stepped;
        if (at_term || step_term) begin
          tc_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end else begin
        q_nxt  = stepped;
        tc_nxt = at_term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q            <= '0;
      tc           <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      oneshot_mode <= 1'b0;
    end else begin
      q            <= q_nxt;
      tc           <= tc_nxt;
      done         <= done_nxt;
      busy         <= (state_nxt == ST_RUN);
      oneshot_mode <= mode_nxt;
    end
  end

`ifdef MODN_CNT_GRAY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      q_gray <= '0;
    end else begin
      q_gray <= W'(gray_of(W_MAX'(q_nxt)));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_modn_sync_counter.sv
// Directed bench for modn_sync_counter: MOD=14 with DIV=1 and DIV=3 instances sharing stimulus.
`default_nettype none

module tb_modn_sync_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, oneshot, start, stop, load;
  logic [3:0] load_val;
  logic [3:0] q1, q3;
  logic       tc1, tc3, busy1, busy3, done1, done3;
`ifdef MODN_CNT_GRAY_EN
  logic [3:0] qg1, qg3;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modn_sync_counter #(.MOD(14), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .oneshot(oneshot),
    .start(start), .stop(stop), .load(load), .load_val(load_val),
    .q(q1), .tc(tc1), .busy(busy1), .done(done1)
`ifdef MODN_CNT_GRAY_EN
    , .q_gray(qg1)
`endif
  );

  modn_sync_counter #(.MOD(14), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .oneshot(oneshot),
    .start(start), .stop(stop), .load(load), .load_val(load_val),
    .q(q3), .tc(tc3), .busy(busy3), .done(done3)
`ifdef MODN_CNT_GRAY_EN
    , .q_gray(qg3)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); cyc();
    total++; if (q1 !== 4'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", q1); end
    total++; if (tc1 !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", tc1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done1); end
    total++; if (q3 !== 4'd0) begin bad++; $display("FAIL reset_q3 got=%0d exp=0", q3); end
  endtask

  task automatic test_free_run_up();
    en = 1'b1; up = 1'b1; oneshot = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    total++; if ({busy1, q1} !== {1'b1, 4'd0}) begin bad++; $display("FAIL fr_start busy/q got=%b/%0d exp=1/0", busy1, q1); end
    for (int i = 1; i <= 13; i++) begin
      cyc();
      total++; if ({q1, tc1} !== {4'(i), 1'b0}) begin bad++; $display("FAIL fr_step%0d q/tc got=%0d/%b exp=%0d/0", i, q1, tc1, i); end
    end
    cyc();
    total++; if ({q1, tc1} !== {4'd0, 1'b1}) begin bad++; $display("FAIL fr_wrap q/tc got=%0d/%b exp=0/1", q1, tc1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd1, 1'b0}) begin bad++; $display("FAIL fr_after q/tc got=%0d/%b exp=1/0", q1, tc1); end
    stop = 1'b1; cyc(); stop = 1'b0;
    total++; if ({busy1, q1} !== {1'b0, 4'd1}) begin bad++; $display("FAIL fr_stop busy/q got=%b/%0d exp=0/1", busy1, q1); end
  endtask

  task automatic test_down();
    load_val = 4'd0; load = 1'b1; cyc(); load = 1'b0;
    total++; if (q1 !== 4'd0) begin bad++; $display("FAIL dn_load q got=%0d exp=0", q1); end
    up = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    total++; if ({busy1, q1} !== {1'b1, 4'd0}) begin bad++; $display("FAIL dn_start busy/q got=%b/%0d exp=1/0", busy1, q1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd13, 1'b1}) begin bad++; $display("FAIL dn_wrap q/tc got=%0d/%b exp=13/1", q1, tc1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd12, 1'b0}) begin bad++; $display("FAIL dn_step q/tc got=%0d/%b exp=12/0", q1, tc1); end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_load();
    load_val = 4'd15; load = 1'b1; cyc(); load = 1'b0;
    total++; if (q1 !== 4'd13) begin bad++; $display("FAIL ld_clamp q got=%0d exp=13", q1); end
    up = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    total++; if ({busy1, q1} !== {1'b1, 4'd13}) begin bad++; $display("FAIL ld_start busy/q got=%b/%0d exp=1/13", busy1, q1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd0, 1'b1}) begin bad++; $display("FAIL ld_wrap q/tc got=%0d/%b exp=0/1", q1, tc1); end
    load_val = 4'd5; load = 1'b1; cyc(); load = 1'b0;
    total++; if ({busy1, q1, tc1} !== {1'b1, 4'd5, 1'b0}) begin bad++; $display("FAIL ld_mid busy/q/tc got=%b/%0d/%b exp=1/5/0", busy1, q1, tc1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd6, 1'b0}) begin bad++; $display("FAIL ld_next q/tc got=%0d/%b exp=6/0", q1, tc1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd7, 1'b0}) begin bad++; $display("FAIL ld_next2 q/tc got=%0d/%b exp=7/0", q1, tc1); end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_oneshot();
    do_reset();
    up = 1'b1; oneshot = 1'b1; start = 1'b1; cyc(); start = 1'b0; oneshot = 1'b0;
    total++; if ({busy1, q1, done1} !== {1'b1, 4'd0, 1'b0}) begin bad++; $display("FAIL os_start busy/q/done got=%b/%0d/%b exp=1/0/0", busy1, q1, done1); end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      total++; if ({q1, tc1, done1} !== {4'(i), 1'b0, 1'b0}) begin bad++; $display("FAIL os_step%0d q/tc/done got=%0d/%b/%b exp=%0d/0/0", i, q1, tc1, done1, i); end
    end
    cyc();
    total++; if ({q1, tc1, done1, busy1} !== {4'd13, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL os_term q/tc/done/busy got=%0d/%b/%b/%b exp=13/1/1/0", q1, tc1, done1, busy1); end
    cyc();
    total++; if ({q1, tc1, done1, busy1} !== {4'd13, 1'b0, 1'b1, 1'b0}) begin bad++; $display("FAIL os_hold q/tc/done/busy got=%0d/%b/%b/%b exp=13/0/1/0", q1, tc1, done1, busy1); end
    start = 1'b1; cyc(); start = 1'b0;
    total++; if ({q1, busy1, done1} !== {4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL os_restart q/busy/done got=%0d/%b/%b exp=0/1/0", q1, busy1, done1); end
    stop = 1'b1; cyc(); stop = 1'b0;
    oneshot = 1'b1; load_val = 4'd13; load = 1'b1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; oneshot = 1'b0;
    cyc();
    total++; if ({q1, tc1, done1, busy1} !== {4'd13, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL os_loaded_term q/tc/done/busy got=%0d/%b/%b/%b exp=13/1/1/0", q1, tc1, done1, busy1); end
    load_val = 4'd2; load = 1'b1; cyc(); load = 1'b0;
    total++; if ({q1, done1, busy1} !== {4'd2, 1'b0, 1'b0}) begin bad++; $display("FAIL os_load_clear q/done/busy got=%0d/%b/%b exp=2/0/0", q1, done1, busy1); end
  endtask

  task automatic test_prescale();
    do_reset();
    up = 1'b1; en = 1'b1; oneshot = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    total++; if ({busy3, q3} !== {1'b1, 4'd0}) begin bad++; $display("FAIL ps_start busy/q got=%b/%0d exp=1/0", busy3, q3); end
    cyc(); cyc();
    total++; if (q3 !== 4'd0) begin bad++; $display("FAIL ps_wait q got=%0d exp=0", q3); end
    cyc();
    total++; if ({q3, tc3} !== {4'd1, 1'b0}) begin bad++; $display("FAIL ps_step1 q/tc got=%0d/%b exp=1/0", q3, tc3); end
    en = 1'b0; cyc(); cyc(); en = 1'b1;
    cyc(); cyc();
    total++; if (q3 !== 4'd1) begin bad++; $display("FAIL ps_stretch q got=%0d exp=1", q3); end
    cyc();
    total++; if (q3 !== 4'd2) begin bad++; $display("FAIL ps_step2 q got=%0d exp=2", q3); end
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    total++; if ({busy3, q3} !== {1'b0, 4'd2}) begin bad++; $display("FAIL ps_stop busy/q got=%b/%0d exp=0/2", busy3, q3); end
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    total++; if (q3 !== 4'd2) begin bad++; $display("FAIL ps_restart_wait q got=%0d exp=2", q3); end
    cyc();
    total++; if (q3 !== 4'd3) begin bad++; $display("FAIL ps_step3 q got=%0d exp=3", q3); end
  endtask

  task automatic test_dir_change();
    do_reset();
    up = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (q1 !== 4'd3) begin bad++; $display("FAIL dir_up q got=%0d exp=3", q1); end
    up = 1'b0; cyc();
    total++; if ({q1, tc1} !== {4'd2, 1'b0}) begin bad++; $display("FAIL dir_down q/tc got=%0d/%b exp=2/0", q1, tc1); end
    cyc();
    total++; if ({q1, tc1} !== {4'd1, 1'b0}) begin bad++; $display("FAIL dir_down2 q/tc got=%0d/%b exp=1/0", q1, tc1); end
    up = 1'b1;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    up = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    repeat (9) cyc();
    total++; if ({busy1, q1} !== {1'b1, 4'd9}) begin bad++; $display("FAIL mr_pre busy/q got=%b/%0d exp=1/9", busy1, q1); end
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if ({q1, busy1, tc1, done1} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL mr_reset q/busy/tc/done got=%0d/%b/%b/%b exp=0/0/0/0", q1, busy1, tc1, done1); end
  endtask

`ifdef MODN_CNT_GRAY_EN
  task automatic test_gray();
    load_val = 4'd7; load = 1'b1; cyc(); load = 1'b0;
    total++; if (qg1 !== 4'd4) begin bad++; $display("FAIL gray7 got=%0d exp=4", qg1); end
    load_val = 4'd8; load = 1'b1; cyc(); load = 1'b0;
    total++; if (qg1 !== 4'd12) begin bad++; $display("FAIL gray8 got=%0d exp=12", qg1); end
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; oneshot = 1'b0;
    start = 1'b0; stop = 1'b0; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_free_run_up();
    test_down();
    test_load();
    test_oneshot();
    test_prescale();
    test_dir_change();
    test_reset_midrun();
`ifdef MODN_CNT_GRAY_EN
    test_gray();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
